// File: rtl/lsu_mem_port.sv
// lsu_mem_port
//   Load/store port between the multicycle core datapath and data memory.
//   Builds byte enables and lane-aligned store data, sign/zero-extends loads,
//   flags misaligned and illegal-size accesses, and aborts a request that the
//   memory leaves unanswered for TIMEOUT cycles.
//
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   start      begin an access (sampled only in IDLE)
//   memwrite   1 = store, 0 = load
//   funct3     RISC-V size/sign code
//   addr       byte address
//   wdata      store data, low bytes used
//   busy       access in progress
//   done       one-cycle completion pulse
//   err        status qualified by done: 00 ok, 01 misaligned, 10 illegal size, 11 timeout
//   load_data  extended load result, held until the next successful load
//   mem_req    memory request, held until mem_ready or timeout
//   mem_we     write enable, valid with mem_req
//   mem_addr   word-aligned address
//   mem_be     byte enables
//   mem_wdata  store data replicated across lanes
//   mem_rdata  read data, valid with mem_ready
//   mem_ready  memory accepts/completes the request this cycle
//
//   state  | meaning
//   IDLE   | waiting for start
//   ACCESS | mem_req asserted, waiting for mem_ready or timeout
//   RESP   | done pulse with err, then back to IDLE
module lsu_mem_port #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              memwrite,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   addr,
   input  logic [XLEN-1:0]   wdata,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err,
   output logic [XLEN-1:0]   load_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_ready
);
   localparam int NB = XLEN / 8;
   localparam int OB = $clog2(NB);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [2:0]       cap_f3;
   logic [OB-1:0]    cap_off;

   logic [OB-1:0]    off_in;
   logic             legal_in;
   logic             misal_in;
   logic [NB-1:0]    be_in;
   logic [XLEN-1:0]  wdata_in;
   logic [XLEN-1:0]  rshift;
   logic [XLEN-1:0]  load_ext;

   assign off_in = addr[OB-1:0];

   // Doubleword and WU exist only on the 64-bit core; unsigned codes make no sense for stores.
   always_comb begin
      legal_in = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b010: legal_in = 1'b1;
         3'b100, 3'b101:         legal_in = !memwrite;
         3'b011:                 legal_in = (XLEN == 64);
         3'b110:                 legal_in = (XLEN == 64) && !memwrite;
         default:                legal_in = 1'b0;
      endcase
   end

   always_comb begin
      misal_in = 1'b0;
      case (funct3[1:0])
         2'b01:   misal_in = off_in[0];
         2'b10:   misal_in = |off_in[1:0];
         2'b11:   misal_in = |off_in;
         default: misal_in = 1'b0;
      endcase
   end

   // Replicating the low bytes puts the data on the enabled lanes for any aligned offset.
   always_comb begin
      be_in    = '0;
      wdata_in = '0;
      case (funct3[1:0])
         2'b00: begin
            be_in    = NB'(1) << off_in;
            wdata_in = {NB{wdata[7:0]}};
         end
         2'b01: begin
            be_in    = NB'(3) << off_in;
            wdata_in = {(NB/2){wdata[15:0]}};
         end
         2'b10: begin
            be_in    = NB'(15) << off_in;
            wdata_in = {(NB/4){wdata[31:0]}};
         end
         default: begin
            be_in    = '1;
            wdata_in = wdata;
         end
      endcase
   end

   assign rshift = mem_rdata >> {cap_off, 3'b000};

   // Size casts of a signed slice sign-extend; of an unsigned slice zero-extend.
   always_comb begin
      load_ext = rshift;
      case (cap_f3)
         3'b000:  load_ext = XLEN'($signed(rshift[7:0]));
         3'b001:  load_ext = XLEN'($signed(rshift[15:0]));
         3'b010:  load_ext = XLEN'($signed(rshift[31:0]));
         3'b100:  load_ext = XLEN'(rshift[7:0]);
         3'b101:  load_ext = XLEN'(rshift[15:0]);
         3'b110:  load_ext = XLEN'(rshift[31:0]);
         default: load_ext = rshift;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         cap_f3    <= '0;
         cap_off   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 2'b00;
         load_data <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cap_f3  <= funct3;
                  cap_off <= off_in;
                  busy    <= 1'b1;
                  if (!legal_in) begin
                     state <= ST_RESP;
                     done  <= 1'b1;
                     err   <= 2'b10;
                  end else if (misal_in) begin
                     state <= ST_RESP;
                     done  <= 1'b1;
                     err   <= 2'b01;
                  end else begin
                     state     <= ST_ACCESS;
                     wait_cnt  <= CNT_W'(TIMEOUT - 1);
                     mem_req   <= 1'b1;
                     mem_we    <= memwrite;
                     mem_addr  <= {addr[XLEN-1:OB], {OB{1'b0}}};
                     mem_be    <= be_in;
                     mem_wdata <= wdata_in;
                  end
               end
            end
            ST_ACCESS: begin
               // wait_cnt counts down the remaining unanswered cycles; zero means this is the last one.
               if (mem_ready || wait_cnt == '0) begin
                  state     <= ST_RESP;
                  done      <= 1'b1;
                  err       <= mem_ready ? 2'b00 : 2'b11;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_be    <= '0;
                  mem_wdata <= '0;
                  if (mem_ready && !mem_we) begin
                     load_data <= load_ext;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               err   <= 2'b00;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               err   <= 2'b00;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;
   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start32 = 1'b0, start64 = 1'b0;
   logic        memwrite = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [63:0] addr = '0, wdata = '0, mem_rdata = '0;
   logic        mem_ready = 1'b0;

   logic        busy32, done32, req32, we32;
   logic [1:0]  err32;
   logic [31:0] ld32, maddr32, mwd32;
   logic [3:0]  be32;
   logic        busy64, done64, req64, we64;
   logic [1:0]  err64;
   logic [63:0] ld64, maddr64, mwd64;
   logic [7:0]  be64;

   int checks = 0;
   int failures = 0;
   logic [63:0] ld_m32 = '0, ld_m64 = '0;

   typedef struct {
      bit          is64;
      bit          we;
      logic [2:0]  f3;
      logic [63:0] a;
      logic [63:0] wd;
      logic [63:0] rd;
      int          ready_at;
   } acc_t;

   always #5 clk = ~clk;

   lsu_mem_port #(.XLEN(32), .TIMEOUT(TIMEOUT), .CNT_W(4)) u_dut32 (
      .clk(clk), .reset(reset), .start(start32), .memwrite(memwrite), .funct3(funct3),
      .addr(addr[31:0]), .wdata(wdata[31:0]), .busy(busy32), .done(done32), .err(err32),
      .load_data(ld32), .mem_req(req32), .mem_we(we32), .mem_addr(maddr32), .mem_be(be32),
      .mem_wdata(mwd32), .mem_rdata(mem_rdata[31:0]), .mem_ready(mem_ready));

   lsu_mem_port #(.XLEN(64), .TIMEOUT(TIMEOUT), .CNT_W(4)) u_dut64 (
      .clk(clk), .reset(reset), .start(start64), .memwrite(memwrite), .funct3(funct3),
      .addr(addr), .wdata(wdata), .busy(busy64), .done(done64), .err(err64),
      .load_data(ld64), .mem_req(req64), .mem_we(we64), .mem_addr(maddr64), .mem_be(be64),
      .mem_wdata(mwd64), .mem_rdata(mem_rdata), .mem_ready(mem_ready));

   // Reference: what one access should produce, from size/offset arithmetic.
   // Cycles are counted from the start edge: done at dcyc, mem_req seen for rcyc cycles.
   function automatic void model(input bit is64, input bit we, input logic [2:0] f3,
         input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
         input int ready_at, input logic [63:0] old_ld,
         output logic [1:0] e, output int dcyc, output int rcyc, output logic [63:0] ma,
         output logic [7:0] be, output logic [63:0] wexp, output logic [63:0] ld);
      int nb;
      int off;
      int bytes;
      int bits;
      bit legal;
      logic [63:0] szmask, xmask, r;
      nb    = is64 ? 8 : 4;
      off   = int'(a % 64'(nb));
      bytes = 1 << f3[1:0];
      bits  = bytes * 8;
      xmask = is64 ? '1 : 64'hFFFF_FFFF;
      case (f3)
         3'd0, 3'd1, 3'd2: legal = 1'b1;
         3'd4, 3'd5:       legal = !we;
         3'd3:             legal = is64;
         3'd6:             legal = is64 && !we;
         default:          legal = 1'b0;
      endcase
      if (!legal) e = 2'b10;
      else if (off % bytes != 0) e = 2'b01;
      else if (ready_at >= 1 && ready_at <= TIMEOUT) e = 2'b00;
      else e = 2'b11;
      if (e == 2'b01 || e == 2'b10) begin
         dcyc = 1;
         rcyc = 0;
      end else if (e == 2'b00) begin
         dcyc = ready_at + 1;
         rcyc = ready_at;
      end else begin
         dcyc = TIMEOUT + 1;
         rcyc = TIMEOUT;
      end
      szmask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
      ma   = (a & xmask) - 64'(off);
      be   = 8'(((1 << bytes) - 1) << off);
      wexp = ((wd & szmask) << (off * 8)) & xmask;
      r    = (rd >> (off * 8)) & szmask;
      if (!f3[2] && bits < 64 && r[bits-1]) r = r | ~szmask;
      r  = r & xmask;
      ld = (e == 2'b00 && !we) ? r : old_ld;
   endfunction

   // Drives one access and records what the selected DUT did; no judging here.
   task automatic run_access(input bit is64, input bit we, input logic [2:0] f3,
         input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
         input int ready_at, input bit poke,
         output int dcyc, output logic [1:0] e, output logic [63:0] ld, output int rcyc,
         output logic [63:0] ma, output logic [7:0] be, output logic [63:0] mwd,
         output logic mwe, output bit unstable, output bit after_ok);
      int cyc;
      bit d, req, bsy;
      logic [63:0] cma, cmwd;
      logic [7:0]  cbe;
      logic        cwe;
      cyc = 0; dcyc = 0; rcyc = 0; e = '0; ld = '0; ma = '0; be = '0; mwd = '0;
      mwe = 1'b0; unstable = 1'b0; after_ok = 1'b0;
      memwrite = we; funct3 = f3; addr = a; wdata = wd;
      if (is64) start64 = 1'b1; else start32 = 1'b1;
      mem_ready = 1'($urandom);
      mem_rdata = {$urandom, $urandom};
      while (cyc < 40 && dcyc == 0) begin
         @(posedge clk); #1;
         cyc++;
         start32 = 1'b0; start64 = 1'b0;
         d   = is64 ? done64 : done32;
         req = is64 ? req64 : req32;
         bsy = is64 ? busy64 : busy32;
         if (d) begin
            dcyc = cyc;
            e    = is64 ? err64 : err32;
            ld   = is64 ? ld64 : 64'(ld32);
         end
         if (req) begin
            rcyc++;
            cma  = is64 ? maddr64 : 64'(maddr32);
            cbe  = is64 ? be64 : 8'(be32);
            cmwd = is64 ? mwd64 : 64'(mwd32);
            cwe  = is64 ? we64 : we32;
            if (rcyc == 1) begin
               ma = cma; be = cbe; mwd = cmwd; mwe = cwe;
            end else if (cma != ma || cbe != be || cmwd != mwd || cwe != mwe) begin
               unstable = 1'b1;
            end
         end
         if (poke && bsy) begin
            if (is64) start64 = 1'b1; else start32 = 1'b1;
            memwrite = ~we;
            funct3   = 3'($urandom);
            addr     = {$urandom, $urandom};
            wdata    = {$urandom, $urandom};
         end
         mem_ready = req ? (rcyc == ready_at) : 1'($urandom);
         mem_rdata = (req && rcyc == ready_at) ? rd : {$urandom, $urandom};
      end
      @(posedge clk); #1;
      start32 = 1'b0; start64 = 1'b0;
      after_ok = is64 ? !(done64 || busy64 || req64) : !(done32 || busy32 || req32);
   endtask

   task automatic test_reset();
      start32 = 1'b1; start64 = 1'b1; mem_ready = 1'b1; funct3 = 3'b010;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy32, done32, err32, ld32, req32, we32, maddr32, be32, mwd32} !== '0) begin
         failures++;
         $display("FAIL reset_outputs32 got busy=%b done=%b req=%b ld=%h addr=%h", busy32, done32, req32, ld32, maddr32);
      end
      checks++;
      if ({busy64, done64, err64, ld64, req64, we64, maddr64, be64, mwd64} !== '0) begin
         failures++;
         $display("FAIL reset_outputs64 got busy=%b done=%b req=%b ld=%h addr=%h", busy64, done64, req64, ld64, maddr64);
      end
      start32 = 1'b0; start64 = 1'b0; mem_ready = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy32 !== 1'b0 || busy64 !== 1'b0 || req32 !== 1'b0 || req64 !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle got busy32=%b busy64=%b req32=%b req64=%b exp all 0", busy32, busy64, req32, req64);
      end
   endtask

   task automatic test_directed();
      acc_t tab[$];
      int dc, rc, edc, erc;
      logic [1:0] e, ee;
      logic [63:0] ld, eld, ma, ema, mwd, ewd, lm;
      logic [7:0] be, ebe;
      logic mwe;
      bit unst, aok;
      string nm;
      tab.push_back('{0, 1, 3'b000, 64'h1003, 64'hAB, 64'h0, 1});
      tab.push_back('{0, 0, 3'b001, 64'h2002, 64'h0, 64'h8001_0000, 3});
      tab.push_back('{0, 0, 3'b101, 64'h2002, 64'h0, 64'h8001_0000, 3});
      tab.push_back('{0, 0, 3'b010, 64'h3001, 64'h0, 64'h0, 1});
      tab.push_back('{0, 0, 3'b011, 64'h4000, 64'h0, 64'h0, 1});
      tab.push_back('{0, 0, 3'b010, 64'h5000, 64'h0, 64'h1234_5678, 0});
      tab.push_back('{0, 0, 3'b010, 64'h5004, 64'h0, 64'h8765_4321, TIMEOUT});
      tab.push_back('{0, 1, 3'b100, 64'h6000, 64'h55, 64'h0, 1});
      tab.push_back('{0, 0, 3'b111, 64'h6000, 64'h0, 64'h0, 1});
      tab.push_back('{0, 1, 3'b001, 64'h7003, 64'hBEEF, 64'h0, 1});
      tab.push_back('{1, 0, 3'b011, 64'h8, 64'h0, 64'h8000_0000_0000_0001, 1});
      tab.push_back('{1, 0, 3'b110, 64'h4, 64'h0, 64'hF000_0000_0000_0000, 1});
      tab.push_back('{1, 1, 3'b010, 64'h14, 64'hDEAD_BEEF, 64'h0, 2});
      tab.push_back('{1, 0, 3'b000, 64'h27, 64'h8000_0000_0000_0000, 64'h0, 1});
      foreach (tab[i]) begin
         nm = $sformatf("dir%0d", i);
         model(tab[i].is64, tab[i].we, tab[i].f3, tab[i].a, tab[i].wd, tab[i].rd, tab[i].ready_at,
               tab[i].is64 ? ld_m64 : ld_m32, ee, edc, erc, ema, ebe, ewd, eld);
         run_access(tab[i].is64, tab[i].we, tab[i].f3, tab[i].a, tab[i].wd, tab[i].rd, tab[i].ready_at,
                    1'b0, dc, e, ld, rc, ma, be, mwd, mwe, unst, aok);
         lm = '0;
         for (int b = 0; b < 8; b++) if (ebe[b]) lm[8*b +: 8] = 8'hFF;
         checks++;
         if (dc !== edc) begin failures++; $display("FAIL %s done_cycle got=%0d exp=%0d", nm, dc, edc); end
         checks++;
         if (e !== ee) begin failures++; $display("FAIL %s err got=%b exp=%b", nm, e, ee); end
         checks++;
         if (ld !== eld) begin failures++; $display("FAIL %s load_data got=%h exp=%h", nm, ld, eld); end
         checks++;
         if (rc !== erc) begin failures++; $display("FAIL %s req_cycles got=%0d exp=%0d", nm, rc, erc); end
         if (erc > 0) begin
            checks++;
            if (ma !== ema || be !== ebe || mwe !== tab[i].we || (mwd & lm) !== ewd || unst) begin
               failures++;
               $display("FAIL %s mem_bus got addr=%h be=%h we=%b wd=%h unstable=%b exp addr=%h be=%h we=%b wd=%h",
                        nm, ma, be, mwe, mwd & lm, unst, ema, ebe, tab[i].we, ewd);
            end
         end
         checks++;
         if (!aok) begin failures++; $display("FAIL %s idle_after got busy/done/req set exp idle", nm); end
         if (tab[i].is64) ld_m64 = eld; else ld_m32 = eld;
      end
   endtask

   task automatic test_random();
      bit is64, we, unst, aok;
      logic [2:0] f3;
      logic [63:0] a, wd, rd, ld, eld, ma, ema, mwd, ewd, lm;
      logic [1:0] e, ee;
      logic [7:0] be, ebe;
      logic mwe;
      int dc, rc, edc, erc, ra, k;
      for (int n = 0; n < 80; n++) begin
         is64 = 1'($urandom); we = 1'($urandom); f3 = 3'($urandom);
         a  = is64 ? {$urandom, $urandom} : {32'h0, $urandom};
         if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << f3[1:0]) - 1);
         wd = is64 ? {$urandom, $urandom} : {32'h0, $urandom};
         rd = is64 ? {$urandom, $urandom} : {32'h0, $urandom};
         k  = $urandom_range(0, 9);
         ra = (k == 0) ? 0 : (k == 1) ? TIMEOUT : $urandom_range(1, 4);
         model(is64, we, f3, a, wd, rd, ra, is64 ? ld_m64 : ld_m32, ee, edc, erc, ema, ebe, ewd, eld);
         run_access(is64, we, f3, a, wd, rd, ra, 1'b0, dc, e, ld, rc, ma, be, mwd, mwe, unst, aok);
         lm = '0;
         for (int b = 0; b < 8; b++) if (ebe[b]) lm[8*b +: 8] = 8'hFF;
         checks++;
         if (dc !== edc || e !== ee) begin
            failures++;
            $display("FAIL rnd%0d done_err got cyc=%0d err=%b exp cyc=%0d err=%b (f3=%b a=%h we=%b x64=%b)",
                     n, dc, e, edc, ee, f3, a, we, is64);
         end
         checks++;
         if (ld !== eld) begin failures++; $display("FAIL rnd%0d load_data got=%h exp=%h", n, ld, eld); end
         checks++;
         if (rc !== erc) begin failures++; $display("FAIL rnd%0d req_cycles got=%0d exp=%0d", n, rc, erc); end
         if (erc > 0) begin
            checks++;
            if (ma !== ema || be !== ebe || mwe !== we || (mwd & lm) !== ewd || unst) begin
               failures++;
               $display("FAIL rnd%0d mem_bus got addr=%h be=%h we=%b wd=%h unstable=%b exp addr=%h be=%h we=%b wd=%h",
                        n, ma, be, mwe, mwd & lm, unst, ema, ebe, we, ewd);
            end
         end
         checks++;
         if (!aok) begin failures++; $display("FAIL rnd%0d idle_after got busy/done/req set exp idle", n); end
         if (is64) ld_m64 = eld; else ld_m32 = eld;
      end
   endtask

   task automatic test_start_during_access();
      acc_t tab[$];
      int dc, rc, edc, erc;
      logic [1:0] e, ee;
      logic [63:0] ld, eld, ma, ema, mwd, ewd;
      logic [7:0] be, ebe;
      logic mwe;
      bit unst, aok;
      tab.push_back('{0, 0, 3'b010, 64'h9000, 64'h0, 64'hCAFE_F00D, 3});
      tab.push_back('{0, 1, 3'b001, 64'h9102, 64'h1234, 64'h0, 2});
      tab.push_back('{1, 0, 3'b011, 64'hA008, 64'h0, 64'h0123_4567_89AB_CDEF, 4});
      foreach (tab[i]) begin
         model(tab[i].is64, tab[i].we, tab[i].f3, tab[i].a, tab[i].wd, tab[i].rd, tab[i].ready_at,
               tab[i].is64 ? ld_m64 : ld_m32, ee, edc, erc, ema, ebe, ewd, eld);
         run_access(tab[i].is64, tab[i].we, tab[i].f3, tab[i].a, tab[i].wd, tab[i].rd, tab[i].ready_at,
                    1'b1, dc, e, ld, rc, ma, be, mwd, mwe, unst, aok);
         checks++;
         if (dc !== edc || e !== ee || rc !== erc) begin
            failures++;
            $display("FAIL poke%0d timing got cyc=%0d err=%b req=%0d exp cyc=%0d err=%b req=%0d", i, dc, e, rc, edc, ee, erc);
         end
         checks++;
         if (ma !== ema || be !== ebe || unst) begin
            failures++;
            $display("FAIL poke%0d mem_hold got addr=%h be=%h unstable=%b exp addr=%h be=%h", i, ma, be, unst, ema, ebe);
         end
         checks++;
         if (ld !== eld) begin failures++; $display("FAIL poke%0d load_data got=%h exp=%h", i, ld, eld); end
         checks++;
         if (!aok) begin failures++; $display("FAIL poke%0d restart_in_resp got busy/done/req set exp idle", i); end
         if (tab[i].is64) ld_m64 = eld; else ld_m32 = eld;
      end
   endtask

   task automatic test_reset_mid_access();
      bit seen_done = 1'b0, seen_busy = 1'b0;
      memwrite = 1'b0; funct3 = 3'b010; addr = 64'h100; wdata = '0; mem_ready = 1'b0;
      start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (req32 !== 1'b1) begin failures++; $display("FAIL rstmid_in_access got req=%b exp=1", req32); end
      reset = 1'b0;
      #1;
      checks++;
      if (req32 !== 1'b0 || busy32 !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_req_drop got req=%b busy=%b exp 0 0", req32, busy32);
      end
      mem_ready = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done32) seen_done = 1'b1;
         if (busy32 || req32) seen_busy = 1'b1;
      end
      checks++;
      if (seen_done) begin failures++; $display("FAIL rstmid_no_done got done=1 exp no done"); end
      checks++;
      if (seen_busy) begin failures++; $display("FAIL rstmid_idle got busy/req=1 exp idle"); end
      checks++;
      if (ld32 !== 32'h0 || ld64 !== 64'h0 || err32 !== 2'b00) begin
         failures++;
         $display("FAIL rstmid_cleared got ld32=%h ld64=%h err=%b exp 0", ld32, ld64, err32);
      end
      mem_ready = 1'b0;
      ld_m32 = '0; ld_m64 = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got no end of run exp finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_start_during_access();
      test_reset_mid_access();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
